// File: rtl/pipe_pc_unit.sv
// Fetch program counter with stall gating, one-deep redirect buffer and trap/eret.
// Optional feature macro: PIPE_PC_ALIGN_CHECK_EN (misaligned redirect targets trap).
module pipe_pc_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      STEP     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'hFFFF_FFFC),
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(32'h0000_0008)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             trap,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic [WIDTH-1:0] epc,
    output logic             fetch_valid,
    output logic             redir_pending,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] tgt;
    logic             take;
`ifdef PIPE_PC_ALIGN_CHECK_EN
    logic             mis_q, mis_d;
`endif

    assign pc_seq = pc_q + WIDTH'(STEP);
    assign pc     = pc_q;
    assign epc    = epc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            pend_q  <= '0;
`ifdef PIPE_PC_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
`ifdef PIPE_PC_ALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // redir_valid is a one-cycle request with no ready: it is either applied,
    // buffered (under stall) or overridden by trap/eret on the edge it is seen.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        pend_d  = pend_q;
        tgt     = '0;
        take    = 1'b0;
`ifdef PIPE_PC_ALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (trap) begin
            pc_d    = TRAP_VEC;
            epc_d   = pc_q;
            state_d = RUN;
        end else if (eret) begin
            pc_d    = epc_q;
            state_d = RUN;
        end else if (stall) begin
            if (redir_valid) begin
                pend_d  = redir_target;
                state_d = HOLD;
            end
        end else if (redir_valid) begin
            take = 1'b1;
            tgt  = redir_target;
        end else if (state_q == HOLD) begin
            take = 1'b1;
            tgt  = pend_q;
        end else begin
            pc_d = pc_seq;
        end

        if (take) begin
            state_d = RUN;
`ifdef PIPE_PC_ALIGN_CHECK_EN
            if ((tgt % WIDTH'(STEP)) != '0) begin
                pc_d  = TRAP_VEC;
                epc_d = tgt;
                mis_d = 1'b1;
            end else begin
                pc_d = tgt;
            end
`else
            pc_d = tgt;
`endif
        end
    end

    always_comb begin
        fetch_valid   = (state_q != BOOT);
        redir_pending = (state_q == HOLD);
`ifdef PIPE_PC_ALIGN_CHECK_EN
        misalign_err  = mis_q;
`else
        misalign_err  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pipe_pc_unit.sv
// Bench for pipe_pc_unit: directed vector table, reset corner cases, then
// randomized traffic against a behavioural PC model.
module tb_pipe_pc_unit;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0008;
`ifdef PIPE_PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, redir_valid, trap, eret;
    logic [31:0] redir_target;
    logic [31:0] pc, pc_seq, epc;
    logic        fetch_valid, redir_pending, misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    pipe_pc_unit dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .trap         (trap),
        .eret         (eret),
        .pc           (pc),
        .pc_seq       (pc_seq),
        .epc          (epc),
        .fetch_valid  (fetch_valid),
        .redir_pending(redir_pending),
        .misalign_err (misalign_err)
    );

    typedef struct {
        logic        s;
        logic        rv;
        logic [31:0] t;
        logic        tr;
        logic        er;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        pend;
        logic        mis;
    } vec_t;

    vec_t        tv[$];
    logic [31:0] exp_q[$];

    // behavioural model state
    logic [31:0] m_pc, m_epc, m_pend;
    bit          m_booted, m_pend_v, m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic rv, input logic [31:0] t, input logic tr,
                       input logic er, input logic [31:0] p, input logic [31:0] e,
                       input logic pend, input logic mis);
        vec_t v;
        v.s = s; v.rv = rv; v.t = t; v.tr = tr; v.er = er;
        v.pc = p; v.epc = e; v.pend = pend; v.mis = mis;
        tv.push_back(v);
    endtask

    task automatic drive(input logic s, input logic rv, input logic [31:0] t,
                         input logic tr, input logic er);
        stall = s; redir_valid = rv; redir_target = t; trap = tr; eret = er;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_epc = '0; m_pend = '0;
        m_booted = 1'b0; m_pend_v = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_jump(input logic [31:0] t);
        if (ALIGN && (t % 4) != 0) begin
            m_epc = t;
            m_pc  = TRAP_VEC;
            m_mis = 1'b1;
        end else begin
            m_pc = t;
        end
    endtask

    task automatic model_step();
        m_mis = 1'b0;
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (trap) begin
            m_epc = m_pc; m_pc = TRAP_VEC; m_pend_v = 1'b0;
        end else if (eret) begin
            m_pc = m_epc; m_pend_v = 1'b0;
        end else if (stall) begin
            if (redir_valid) begin
                m_pend_v = 1'b1; m_pend = redir_target;
            end
        end else begin
            if (redir_valid) model_jump(redir_target);
            else if (m_pend_v) model_jump(m_pend);
            else m_pc = m_pc + 32'd4;
            m_pend_v = 1'b0;
        end
    endtask

    initial begin
        // stall rv target trap eret | pc epc pend mis
        add(0,0,0,0,0, RESET_PC, 0, 0, 0);
        add(0,0,0,0,0, 32'h0, 0, 0, 0);
        add(0,0,0,0,0, 32'h4, 0, 0, 0);
        add(0,0,0,0,0, 32'h8, 0, 0, 0);
        add(0,1,32'h40,0,0, 32'h40, 0, 0, 0);
        add(1,0,0,0,0, 32'h40, 0, 0, 0);
        add(1,1,32'h100,0,0, 32'h40, 0, 1, 0);
        add(1,0,0,0,0, 32'h40, 0, 1, 0);
        add(0,0,0,0,0, 32'h100, 0, 0, 0);
        add(0,0,0,0,0, 32'h104, 0, 0, 0);
        add(1,1,32'h100,0,0, 32'h104, 0, 1, 0);
        add(0,1,32'h200,0,0, 32'h200, 0, 0, 0);
        add(0,0,0,0,0, 32'h204, 0, 0, 0);
        add(0,1,32'h80,0,0, 32'h80, 0, 0, 0);
        add(1,0,0,1,0, TRAP_VEC, 32'h80, 0, 0);
        add(0,0,0,0,0, 32'hC, 32'h80, 0, 0);
        add(0,0,0,0,1, 32'h80, 32'h80, 0, 0);
        add(1,1,32'h300,0,0, 32'h80, 32'h80, 1, 0);
        add(1,1,32'h400,0,0, 32'h80, 32'h80, 1, 0);
        add(0,0,0,0,0, 32'h400, 32'h80, 0, 0);
        add(0,0,0,1,1, TRAP_VEC, 32'h400, 0, 0);
        add(1,1,32'h500,0,0, TRAP_VEC, 32'h400, 1, 0);
        add(1,0,0,1,0, TRAP_VEC, TRAP_VEC, 0, 0);
        add(0,0,0,0,0, 32'hC, TRAP_VEC, 0, 0);
        add(1,1,32'h600,0,0, 32'hC, TRAP_VEC, 1, 0);
        add(1,0,0,0,1, TRAP_VEC, TRAP_VEC, 0, 0);
        add(0,0,0,0,0, 32'hC, TRAP_VEC, 0, 0);
        add(0,1,32'hFFFF_FFF8,0,0, 32'hFFFF_FFF8, TRAP_VEC, 0, 0);
        add(0,0,0,0,0, 32'hFFFF_FFFC, TRAP_VEC, 0, 0);
        add(0,0,0,0,0, 32'h0, TRAP_VEC, 0, 0);
        add(0,1,32'h102,0,0, ALIGN ? TRAP_VEC : 32'h102, ALIGN ? 32'h102 : TRAP_VEC, 0, ALIGN);
        add(0,0,0,0,0, ALIGN ? 32'hC : 32'h106, ALIGN ? 32'h102 : TRAP_VEC, 0, 0);
        add(1,1,32'h203,0,0, ALIGN ? 32'hC : 32'h106, ALIGN ? 32'h102 : TRAP_VEC, 1, 0);
        add(0,0,0,0,0, ALIGN ? TRAP_VEC : 32'h203, ALIGN ? 32'h203 : TRAP_VEC, 0, ALIGN);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        #3;
        check("rst pc", pc, RESET_PC);
        check("rst fv", {31'b0, fetch_valid}, 0);
        check("rst pend", {31'b0, redir_pending}, 0);
        check("rst epc", epc, 0);
        check("rst mis", {31'b0, misalign_err}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #2;
        check("boot pc", pc, RESET_PC);
        check("boot fv", {31'b0, fetch_valid}, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].s, tv[i].rv, tv[i].t, tv[i].tr, tv[i].er);
            step();
            check($sformatf("row%0d pc", i), pc, tv[i].pc);
            check($sformatf("row%0d pc_seq", i), pc_seq, tv[i].pc + 32'd4);
            check($sformatf("row%0d epc", i), epc, tv[i].epc);
            check($sformatf("row%0d pend", i), {31'b0, redir_pending}, {31'b0, tv[i].pend});
            check($sformatf("row%0d mis", i), {31'b0, misalign_err}, {31'b0, tv[i].mis});
            check($sformatf("row%0d fv", i), {31'b0, fetch_valid}, 1);
        end

        // asynchronous reset mid-cycle with a redirect buffered
        drive(1, 1, 32'h700, 0, 0);
        step();
        check("pre-rst pend", {31'b0, redir_pending}, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async rst pc", pc, RESET_PC);
        check("async rst pend", {31'b0, redir_pending}, 0);
        check("async rst fv", {31'b0, fetch_valid}, 0);
        check("async rst epc", epc, 0);
        drive(0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        step();
        check("post-rst boot pc", pc, RESET_PC);
        check("post-rst fv", {31'b0, fetch_valid}, 1);
        step();
        check("post-rst seq pc", pc, 32'h0);
        check("post-rst pend", {31'b0, redir_pending}, 0);

        // randomized traffic against the model
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
        for (int c = 0; c < 800; c++) begin
            logic [31:0] t;
            t = 32'($urandom_range(0, 1023)) * 32'd4;
            if ($urandom_range(0, 3) == 0) t = t + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, t,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
            @(posedge clock);
            model_step();
            exp_q.push_back(m_pc);
            #1;
            check($sformatf("rnd%0d pc", c), pc, exp_q.pop_front());
            check($sformatf("rnd%0d pc_seq", c), pc_seq, m_pc + 32'd4);
            check($sformatf("rnd%0d epc", c), epc, m_epc);
            check($sformatf("rnd%0d pend", c), {31'b0, redir_pending}, {31'b0, m_pend_v});
            check($sformatf("rnd%0d mis", c), {31'b0, misalign_err}, {31'b0, m_mis});
            check($sformatf("rnd%0d fv", c), {31'b0, fetch_valid}, {31'b0, m_booted});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_pc_unit.md
# pipe_pc_unit

Parametrised program-counter stage for the pipelined CPU front end. Holds the fetch PC and advances it by a fixed step when not stalled. Accepts branch/jump redirects, buffering one that arrives during a stall until the stall releases. Takes a trap to a fixed vector, saving the interrupted PC, and returns from it on `eret`. Sits between the next-PC logic and the instruction memory, and replaces the plain stall-gated PC register.

## Interface
- `WIDTH`, 32: PC width in bits.
- `STEP`, 4: sequential increment.
- `RESET_PC`, 32'hFFFF_FFFC (-4): PC value during and after reset; the first sequential advance reaches 0.
- `TRAP_VEC`, 32'h0000_0008: trap handler address.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC (load-use / hazard stall); 1 = freeze.
- `redir_valid`  in  1  redirect request this cycle.
- `redir_target`  in  WIDTH  redirect address.
- `trap`  in  1  exception request.
- `eret`  in  1  return from exception.
- `pc`  out  WIDTH  current fetch address (registered).
- `pc_seq`  out  WIDTH  `pc + STEP`, combinational, modulo 2^WIDTH.
- `epc`  out  WIDTH  PC saved at last trap (registered).
- `fetch_valid`  out  1  `pc` is a real fetch address (registered).
- `redir_pending`  out  1  a buffered redirect is waiting (registered).
- `misalign_err`  out  1  one-cycle pulse; see Configuration.

## Operation
- State machine: BOOT, RUN, HOLD.
  - BOOT is entered on reset.
  - BOOT goes to RUN on the first rising edge after `reset` deasserts. All inputs are ignored in BOOT, and `pc` stays RESET_PC.
  - RUN: `redir_pending` = 0.
  - HOLD: `redir_pending` = 1 and a target is in the pending register.
- Per-edge priority in RUN/HOLD, highest first:
  1. `trap`: `pc` <= TRAP_VEC, `epc` <= `pc`, pending cleared, state to RUN. Applies regardless of `stall`.
  2. `eret`: `pc` <= `epc`, pending cleared, state to RUN. Applies regardless of `stall`.
  3. `stall`=1 with `redir_valid`=1: pending <= `redir_target`, state to HOLD, `pc` unchanged. A later stalled redirect overwrites the buffer (youngest wins).
  4. `stall`=1 with no redirect: `pc`, pending and state all unchanged.
  5. `stall`=0 with `redir_valid`=1: `pc` <= `redir_target`, pending cleared, state to RUN. A live redirect beats a buffered one.
  6. `stall`=0 in HOLD: `pc` <= pending target, state to RUN.
  7. Otherwise: `pc` <= `pc_seq`.
- `trap` and `eret` in the same cycle: `trap` wins, and `epc` is overwritten with the current `pc`.
- Nested traps overwrite `epc`; no stack.
- `pc` wraps modulo 2^WIDTH: from 2^WIDTH−STEP the next sequential value is 0.

## Timing
- Reset values: `pc` = RESET_PC, `epc` = 0, `fetch_valid` = 0, `redir_pending` = 0, `misalign_err` = 0, state = BOOT.
- Asserting `reset` mid-operation immediately forces these values and discards any pending redirect.
- `fetch_valid` rises on the edge leaving BOOT and then stays 1 until reset.
- Latency: every accepted input changes `pc` on the next rising edge (1 cycle). A buffered redirect appears on the edge where `stall` is first sampled 0.
- `pc_seq` follows `pc` combinationally with zero latency.
- `redir_pending` and `epc` update on the same edge as the event that sets or changes them.

## Configuration
- Macro: `PIPE_PC_ALIGN_CHECK_EN`.
- Defined: a redirect target (live or buffered) with `target % STEP` ≠ 0 is not taken when it would be applied. Instead:
  - it behaves as a trap: `pc` <= TRAP_VEC, `epc` <= offending target, pending cleared;
  - `misalign_err` pulses 1 for exactly one cycle after that edge.
  - Misaligned targets buffered during a stall are checked on release, not on capture.
- Undefined: targets are loaded verbatim and `misalign_err` is tied 0. The port is always present.

## Test plan
- Reset, release, no stall: `pc` is FFFF_FFFC and `fetch_valid`=0 during BOOT, then FFFF_FFFC with `fetch_valid`=1, then 0, 4, 8 on successive edges.
- In RUN at `pc`=0x40, assert `stall` for 3 cycles with `redir_valid`/`redir_target`=0x100 in the 2nd cycle:
  - `pc` holds 0x40 and `redir_pending`=1 after the 2nd cycle;
  - on release `pc`=0x100, then 0x104.
- Stalled with pending 0x100, release `stall` while driving `redir_valid`/`redir_target`=0x200 in the same cycle: `pc`=0x200 and `redir_pending`=0.
- At `pc`=0x80 with `stall`=1, assert `trap`: `pc`=0x08, `epc`=0x80. Two cycles later assert `eret`: `pc`=0x80.
- Start at `pc`=FFFF_FFF8 with no stall: sequence is FFFF_FFFC, 0.
- With `PIPE_PC_ALIGN_CHECK_EN` defined, redirect to 0x102: `pc`=0x08, `epc`=0x102, and `misalign_err` high for one cycle.
- With the macro undefined, the same redirect gives `pc`=0x102 and `misalign_err`=0.
